// File: rtl/tri_pkg.sv
// Shared types and widths for the triangle scheduler and its engine.
package tri_pkg;

    localparam int unsigned COORD_W = 3;
    localparam int unsigned VTX_W   = 18;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned PIX_MAX = 64;
    localparam int unsigned WD_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD1,
        ST_LOAD2,
        ST_LOAD3,
        ST_GAP,
        ST_RUN
    } tri_state_e;

    // x1 occupies the MSBs of the raw bundle
    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
        logic [COORD_W-1:0] x3;
        logic [COORD_W-1:0] y3;
    } tri_vtx_t;

endpackage

// File: rtl/tri_sched_if.sv
// Requester, engine and result signals of the triangle scheduler.
interface tri_sched_if;
    import tri_pkg::*;

    logic [1:0]         req;
    logic [VTX_W-1:0]   vtx0;
    logic [VTX_W-1:0]   vtx1;
    logic [1:0]         gnt;
    logic               eng_nt;
    logic [COORD_W-1:0] eng_xi;
    logic [COORD_W-1:0] eng_yi;
    logic               eng_busy;
    logic               eng_po;
    logic [COORD_W-1:0] eng_xo;
    logic [COORD_W-1:0] eng_yo;
    logic               pix_valid;
    logic               pix_id;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               done;
    logic               done_id;
    logic [CNT_W-1:0]   done_cnt;
    logic               done_err;

    modport slave (
        input  req, vtx0, vtx1, eng_busy, eng_po, eng_xo, eng_yo,
        output gnt, eng_nt, eng_xi, eng_yi, pix_valid, pix_id, pix_x, pix_y,
               done, done_id, done_cnt, done_err
    );

    modport master (
        output req, vtx0, vtx1, eng_busy, eng_po, eng_xo, eng_yo,
        input  gnt, eng_nt, eng_xi, eng_yi, pix_valid, pix_id, pix_x, pix_y,
               done, done_id, done_cnt, done_err
    );

endinterface

// File: rtl/tri_rr_arb.sv
// Two-way round-robin arbiter; the pointer names the preferred requester.
module tri_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt_c
);

    logic       r_ptr;
    logic [1:0] w_gnt;

    // a lone requester wins regardless of the pointer
    always_comb begin
        w_gnt    = 2'b00;
        w_gnt[0] = i_en & i_req[0] & (~r_ptr | ~i_req[1]);
        w_gnt[1] = i_en & i_req[1] & ( r_ptr | ~i_req[0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (|w_gnt) begin
            r_ptr <= w_gnt[0];
        end
    end

    assign o_gnt_c = w_gnt;

endmodule

// File: rtl/tri_sched.sv
// Triangle job scheduler: arbitrates two requesters, loads the engine,
// forwards its pixels and reports job completion or watchdog abort.
module tri_sched
    import tri_pkg::*;
#(
    parameter int unsigned WDOG = 200
) (
    input  logic        clk,
    input  logic        reset,
    tri_sched_if.slave  bus
);

    tri_state_e         r_state;
    tri_state_e         w_state_nxt;
    tri_vtx_t           r_vtx;
    logic               r_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WD_W-1:0]    r_wdog;
    logic               r_done;
    logic               r_done_id;
    logic [CNT_W-1:0]   r_done_cnt;
    logic               r_done_err;

    logic [1:0]         w_gnt;
    logic               w_grant_en;
    logic               w_granted;
    logic               w_pix;
    logic               w_wd_hit;
    logic               w_finish;
    logic               w_nt;
    logic [COORD_W-1:0] w_xi;
    logic [COORD_W-1:0] w_yi;

    assign w_grant_en = (r_state == ST_IDLE) & ~bus.eng_busy & ~reset;
    assign w_granted  = |w_gnt;

    tri_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   (bus.req),
        .i_en    (w_grant_en),
        .o_gnt_c (w_gnt)
    );

    // pixels are forwarded only while a job owns the engine
    assign w_pix     = bus.eng_po & (r_state != ST_IDLE) & ~reset;
    assign w_cnt_nxt = (w_pix && (r_cnt != CNT_W'(PIX_MAX))) ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_wd_hit  = (r_wdog == WD_W'(WDOG - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        w_nt        = 1'b0;
        w_xi        = '0;
        w_yi        = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_granted) begin
                    w_state_nxt = ST_LOAD1;
                end
            end
            ST_LOAD1: begin
                w_nt        = 1'b1;
                w_xi        = r_vtx.x1;
                w_yi        = r_vtx.y1;
                w_state_nxt = ST_LOAD2;
            end
            ST_LOAD2: begin
                w_xi        = r_vtx.x2;
                w_yi        = r_vtx.y2;
                w_state_nxt = ST_LOAD3;
            end
            ST_LOAD3: begin
                w_xi        = r_vtx.x3;
                w_yi        = r_vtx.y3;
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.eng_busy || w_wd_hit) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // job context, pixel counter, watchdog and the done report
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vtx      <= '0;
            r_id       <= 1'b0;
            r_cnt      <= '0;
            r_wdog     <= '0;
            r_done     <= 1'b0;
            r_done_id  <= 1'b0;
            r_done_cnt <= '0;
            r_done_err <= 1'b0;
        end else begin
            if (w_granted) begin
                r_vtx <= tri_vtx_t'(w_gnt[1] ? bus.vtx1 : bus.vtx0);
                r_id  <= w_gnt[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_nxt;
            end

            if (r_state == ST_GAP) begin
                r_wdog <= '0;
            end else if (r_state == ST_RUN) begin
                r_wdog <= r_wdog + WD_W'(1);
            end

            r_done     <= w_finish;
            r_done_id  <= w_finish & r_id;
            r_done_cnt <= w_finish ? w_cnt_nxt : '0;
            r_done_err <= w_finish & bus.eng_busy;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.eng_nt    = w_nt;
    assign bus.eng_xi    = w_xi;
    assign bus.eng_yi    = w_yi;
    assign bus.pix_valid = w_pix;
    assign bus.pix_id    = w_pix & r_id;
    assign bus.pix_x     = w_pix ? bus.eng_xo : '0;
    assign bus.pix_y     = w_pix ? bus.eng_yo : '0;
    assign bus.done      = r_done;
    assign bus.done_id   = r_done_id;
    assign bus.done_cnt  = r_done_cnt;
    assign bus.done_err  = r_done_err;

endmodule

// File: tb/tb_tri_sched.sv
// Directed bench for tri_sched with scoreboards for pixels and done reports.
module tb_tri_sched;
    import tri_pkg::*;

    localparam logic [17:0] V_SPEC = {3'd1, 3'd0, 3'd1, 3'd5, 3'd5, 3'd3};
    localparam logic [17:0] V_A    = {3'd2, 3'd7, 3'd4, 3'd1, 3'd6, 3'd3};
    localparam logic [17:0] V_B    = {3'd7, 3'd6, 3'd0, 3'd2, 3'd3, 3'd5};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tri_sched_if bus ();
    tri_sched_if bus_w ();

    tri_sched u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    tri_sched #(.WDOG(8)) u_dut_wd (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    typedef struct {
        int id;
        int cnt;
        int err;
        int at;
    } done_exp_t;

    done_exp_t   q_done[$];
    logic [6:0]  q_pix[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;

    logic [1:0] exp_gnt;
    logic       exp_nt;
    logic       exp_pv;
    logic [2:0] exp_xi;
    logic [2:0] exp_yi;
    logic [1:0] exp_w_gnt;
    logic       exp_w_done;
    logic       exp_w_err;
    logic [6:0] exp_w_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_pt(input tri_vtx_t v, input int k);
        case (k)
            0:       return {v.x1, v.y1};
            1:       return {v.x2, v.y2};
            2:       return {v.x3, v.y3};
            default: return 6'd0;
        endcase
    endfunction

    // one clock: sample both DUTs at the falling edge, then advance
    task automatic cyc();
        done_exp_t  d;
        logic [6:0] p;
        @(negedge clk);
        chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
        chk("eng_nt", 32'(bus.eng_nt), 32'(exp_nt));
        chk("eng_xi", 32'(bus.eng_xi), 32'(exp_xi));
        chk("eng_yi", 32'(bus.eng_yi), 32'(exp_yi));
        chk("pix_valid", 32'(bus.pix_valid), 32'(exp_pv));
        if (bus.pix_valid === 1'b1) begin
            chk("pix_expected", 32'(q_pix.size() != 0), 32'd1);
            if (q_pix.size() != 0) begin
                p = q_pix.pop_front();
                chk("pix_id_x_y", 32'({bus.pix_id, bus.pix_x, bus.pix_y}), 32'(p));
            end
        end
        if (bus.done === 1'b1) begin
            chk("done_expected", 32'(q_done.size() != 0), 32'd1);
            if (q_done.size() != 0) begin
                d = q_done.pop_front();
                chk("done_id", 32'(bus.done_id), 32'(d.id));
                chk("done_cnt", 32'(bus.done_cnt), 32'(d.cnt));
                chk("done_err", 32'(bus.done_err), 32'(d.err));
                chk("done_cycle", 32'(cyc_n), 32'(d.at));
            end
        end else begin
            chk("done_fields_idle", 32'({bus.done, bus.done_id, bus.done_cnt, bus.done_err}), 32'd0);
        end
        chk("wd_gnt", 32'(bus_w.gnt), 32'(exp_w_gnt));
        chk("wd_done", 32'(bus_w.done), 32'(exp_w_done));
        if (exp_w_done) begin
            chk("wd_done_err", 32'(bus_w.done_err), 32'(exp_w_err));
            chk("wd_done_cnt", 32'(bus_w.done_cnt), 32'(exp_w_cnt));
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // grant cycle for requester id, then engine busy for b cycles from LOAD1
    // with npo pixel pulses; npo may be b+1 to land a pixel on the done cycle
    task automatic job(input int id, input logic [17:0] v, input int npo, input int b);
        tri_vtx_t vs;
        vs           = tri_vtx_t'(v);
        exp_gnt      = 2'(1 << id);
        exp_nt       = 1'b0;
        exp_xi       = 3'd0;
        exp_yi       = 3'd0;
        exp_pv       = 1'b0;
        bus.eng_busy = 1'b0;
        bus.eng_po   = 1'b0;
        q_done.push_back('{id: id, cnt: (npo > 64) ? 64 : npo, err: 0, at: cyc_n + b + 2});
        cyc();
        bus.req[id] = 1'b0;
        exp_gnt     = 2'b00;
        for (int k = 0; k <= b; k++) begin
            bus.eng_busy     = (k < b);
            bus.eng_po       = (k < npo);
            bus.eng_xo       = 3'(k);
            bus.eng_yo       = 3'(k / 8);
            exp_nt           = (k == 0);
            {exp_xi, exp_yi} = exp_pt(vs, k);
            exp_pv           = bus.eng_po;
            if (bus.eng_po) q_pix.push_back({1'(id), bus.eng_xo, bus.eng_yo});
            cyc();
        end
        bus.eng_busy = 1'b0;
        bus.eng_po   = 1'b0;
        exp_nt       = 1'b0;
        exp_xi       = 3'd0;
        exp_yi       = 3'd0;
        exp_pv       = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.req      = 2'b00;
        bus.vtx0     = V_A;
        bus.vtx1     = V_B;
        bus.eng_busy = 1'b0;
        bus.eng_po   = 1'b0;
        bus.eng_xo   = 3'd0;
        bus.eng_yo   = 3'd0;
        bus_w.req      = 2'b00;
        bus_w.vtx0     = V_A;
        bus_w.vtx1     = V_B;
        bus_w.eng_busy = 1'b0;
        bus_w.eng_po   = 1'b0;
        bus_w.eng_xo   = 3'd0;
        bus_w.eng_yo   = 3'd0;
        exp_gnt    = 2'b00;
        exp_nt     = 1'b0;
        exp_pv     = 1'b0;
        exp_xi     = 3'd0;
        exp_yi     = 3'd0;
        exp_w_gnt  = 2'b00;
        exp_w_done = 1'b0;
        exp_w_err  = 1'b0;
        exp_w_cnt  = 7'd0;

        // reset state, requests held during reset must not be granted
        bus.req = 2'b11;
        cyc();
        cyc();

        // contention straight out of reset: 01,10,01,10
        reset = 1'b0;
        job(0, V_A, 3, 5);
        job(1, V_B, 4, 5);
        bus.req = 2'b11;
        job(0, V_A, 0, 4);
        job(1, V_B, 5, 4);

        // engine busy in IDLE blocks the grant
        bus.vtx0     = V_SPEC;
        bus.req      = 2'b01;
        bus.eng_busy = 1'b1;
        cyc();
        cyc();

        // single job with the reference triangle, last pixel on the done cycle
        job(0, V_SPEC, 7, 6);

        // stray engine pixel while idle
        bus.eng_po = 1'b1;
        bus.eng_xo = 3'd6;
        bus.eng_yo = 3'd2;
        cyc();
        cyc();
        bus.eng_po = 1'b0;

        // saturation of the pixel count
        bus.req = 2'b10;
        job(1, V_B, 70, 70);

        // reset while running; pending req1 granted right after
        bus.vtx0     = V_A;
        bus.req      = 2'b01;
        exp_gnt      = 2'b01;
        cyc();
        bus.req      = 2'b10;
        exp_gnt      = 2'b00;
        bus.eng_busy = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            exp_nt           = (k == 0);
            {exp_xi, exp_yi} = exp_pt(tri_vtx_t'(V_A), k);
            cyc();
        end
        reset  = 1'b1;
        exp_nt = 1'b0;
        exp_xi = 3'd0;
        exp_yi = 3'd0;
        cyc();
        reset = 1'b0;
        job(1, V_B, 2, 4);

        // watchdog abort on the WDOG=8 instance
        bus_w.req = 2'b01;
        exp_w_gnt = 2'b01;
        cyc();
        bus_w.req      = 2'b00;
        exp_w_gnt      = 2'b00;
        bus_w.eng_busy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus_w.eng_po = (k < 3);
            cyc();
        end
        bus_w.eng_po   = 1'b0;
        bus_w.eng_busy = 1'b0;
        bus_w.req      = 2'b10;
        exp_w_gnt      = 2'b10;
        exp_w_done     = 1'b1;
        exp_w_err      = 1'b1;
        exp_w_cnt      = 7'd3;
        cyc();
        bus_w.req  = 2'b00;
        exp_w_gnt  = 2'b00;
        exp_w_done = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        exp_w_done = 1'b1;
        exp_w_err  = 1'b0;
        exp_w_cnt  = 7'd0;
        cyc();
        exp_w_done = 1'b0;

        cyc();
        cyc();
        chk("pix_queue_drained", 32'(q_pix.size()), 32'd0);
        chk("done_queue_drained", 32'(q_done.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
